// File: rtl/diffusion_scheduler.sv
// Shares one score-BRAM port among NUM_ENG diffusion engines (round-robin)
// and paces the diffusion steps through l_step / rdy / finished_all / done.
module diffusion_scheduler #(
  parameter int unsigned NUM_ENG    = 4,
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_STEPS  = 7
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [NUM_ENG-1:0]            eng_req_i,
  input  logic [NUM_ENG-1:0]            eng_we_i,
  input  logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_i,
  input  logic [NUM_ENG*DATA_WIDTH-1:0] eng_wdata_i,
  input  logic [NUM_ENG-1:0]            eng_finished_i,
  output logic [NUM_ENG-1:0]            conflict_o,
  output logic [DATA_WIDTH-1:0]         eng_rdata_o,
  output logic [NUM_ENG-1:0]            eng_rvalid_o,
  output logic [ADDR_WIDTH-1:0]         bram_addr_o,
  output logic [DATA_WIDTH-1:0]         bram_din_o,
  output logic                          bram_we_o,
  input  logic [DATA_WIDTH-1:0]         bram_dout_i,
  output logic [DATA_WIDTH-1:0]         l_step_o,
  output logic                          rdy_o,
  output logic                          finished_all_o,
  output logic                          done_o
);

  localparam int unsigned IDX_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STEP_END = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  l_step_q, l_step_d;
  logic                   rdy_q, rdy_d;
  logic                   fin_all_q, fin_all_d;
  logic                   done_q, done_d;
  logic [NUM_ENG-1:0]     sticky_q, sticky_d;
  logic [NUM_ENG-1:0]     fin_eff;

  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       grant_idx;
  logic [IDX_W-1:0]       cand;
  logic                   grant_vld;
  logic [NUM_ENG-1:0]     grant_oh;
  logic [NUM_ENG-1:0]     rvalid_q, rvalid_d;
  logic [ADDR_WIDTH-1:0]  last_addr_q, last_addr_d;
  logic [DATA_WIDTH-1:0]  last_din_q, last_din_d;

  logic [ADDR_WIDTH-1:0]  addr_a  [NUM_ENG];
  logic [DATA_WIDTH-1:0]  wdata_a [NUM_ENG];

  // Unpack the per-engine address/data buses
  always_comb begin
    for (int i = 0; i < NUM_ENG; i++) begin
      addr_a[i]  = eng_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_a[i] = eng_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Round-robin search starting at rr_ptr; only arbitrates while running
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    cand      = '0;
    if (state_q == RUN) begin
      for (int unsigned k = 0; k < NUM_ENG; k++) begin
        cand = IDX_W'((32'(rr_ptr_q) + k) % NUM_ENG);
        if (!grant_vld && eng_req_i[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
    grant_oh[grant_idx] = grant_vld;
  end

  // Pointer, held BRAM address/data and read-return tracking
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    last_addr_d = last_addr_q;
    last_din_d  = last_din_q;
    rvalid_d    = '0;
    if (grant_vld) begin
      rr_ptr_d    = (grant_idx == IDX_W'(NUM_ENG - 1)) ? '0 : grant_idx + IDX_W'(1);
      last_addr_d = addr_a[grant_idx];
      last_din_d  = wdata_a[grant_idx];
      if (!eng_we_i[grant_idx]) begin
        rvalid_d = grant_oh;
      end
    end
  end

  assign bram_we_o    = grant_vld & eng_we_i[grant_idx];
  assign bram_addr_o  = grant_vld ? addr_a[grant_idx]  : last_addr_q;
  assign bram_din_o   = grant_vld ? wdata_a[grant_idx] : last_din_q;
  assign conflict_o   = eng_req_i & ~grant_oh;
  assign eng_rvalid_o = rvalid_q;
  // BRAM output register is the read stage; gate it so idle cycles read as zero
  assign eng_rdata_o  = (|rvalid_q) ? bram_dout_i : '0;

  assign l_step_o       = l_step_q;
  assign rdy_o          = rdy_q;
  assign finished_all_o = fin_all_q;
  assign done_o         = done_q;

  // Finished reports in the restart-pulse cycle are stale from the prior step
  assign fin_eff = fin_all_q ? '0 : eng_finished_i;

  // Step FSM next-state and registered outputs
  always_comb begin
    state_d   = state_q;
    l_step_d  = l_step_q;
    rdy_d     = rdy_q;
    fin_all_d = 1'b0;
    done_d    = done_q;
    sticky_d  = sticky_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d   = RUN;
          l_step_d  = '0;
          rdy_d     = 1'b1;
          fin_all_d = 1'b1;
          done_d    = 1'b0;
          sticky_d  = '0;
        end
      end
      RUN: begin
        sticky_d = sticky_q | fin_eff;
        if (&sticky_d) begin
          state_d  = STEP_END;
          rdy_d    = 1'b0;
          sticky_d = '0;
          l_step_d = l_step_q + DATA_WIDTH'(1);
        end
      end
      STEP_END: begin
        if (l_step_q == DATA_WIDTH'(MAX_STEPS)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d   = RUN;
          rdy_d     = 1'b1;
          fin_all_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      l_step_q    <= '0;
      rdy_q       <= 1'b0;
      fin_all_q   <= 1'b0;
      done_q      <= 1'b0;
      sticky_q    <= '0;
      rr_ptr_q    <= '0;
      rvalid_q    <= '0;
      last_addr_q <= '0;
      last_din_q  <= '0;
    end else begin
      state_q     <= state_d;
      l_step_q    <= l_step_d;
      rdy_q       <= rdy_d;
      fin_all_q   <= fin_all_d;
      done_q      <= done_d;
      sticky_q    <= sticky_d;
      rr_ptr_q    <= rr_ptr_d;
      rvalid_q    <= rvalid_d;
      last_addr_q <= last_addr_d;
      last_din_q  <= last_din_d;
    end
  end

endmodule

// File: tb/tb_diffusion_scheduler.sv
// Bench for diffusion_scheduler: behavioural 1-cycle BRAM, read-return
// scoreboard, and per-scenario tasks covering arbitration and step pacing.
module tb_diffusion_scheduler;

  localparam int NE = 4;
  localparam int AW = 13;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [NE-1:0]     eng_req;
  logic [NE-1:0]     eng_we;
  logic [NE*AW-1:0]  eng_addr;
  logic [NE*DW-1:0]  eng_wdata;
  logic [NE-1:0]     eng_finished;
  logic [NE-1:0]     conflict;
  logic [DW-1:0]     eng_rdata;
  logic [NE-1:0]     eng_rvalid;
  logic [AW-1:0]     bram_addr;
  logic [DW-1:0]     bram_din;
  logic              bram_we;
  logic [DW-1:0]     bram_dout;
  logic [DW-1:0]     l_step;
  logic              rdy;
  logic              finished_all;
  logic              done;

  int checks = 0;
  int errors = 0;
  int exp_ptr = 0;
  logic mon_en = 1'b0;

  typedef struct {
    logic [NE-1:0] oh;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  diffusion_scheduler #(
    .NUM_ENG(NE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_STEPS(3)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .eng_req_i(eng_req), .eng_we_i(eng_we), .eng_addr_i(eng_addr),
    .eng_wdata_i(eng_wdata), .eng_finished_i(eng_finished),
    .conflict_o(conflict), .eng_rdata_o(eng_rdata), .eng_rvalid_o(eng_rvalid),
    .bram_addr_o(bram_addr), .bram_din_o(bram_din), .bram_we_o(bram_we),
    .bram_dout_i(bram_dout), .l_step_o(l_step), .rdy_o(rdy),
    .finished_all_o(finished_all), .done_o(done)
  );

  // Score BRAM: unwritten words read back a fixed address-derived pattern
  logic [DW-1:0] wmem [8192];
  logic [8191:0] wvld;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == 13'd5) ? 32'h0000_00AB : (32'h0000_1000 + 32'(a));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      wvld <= '0;
    end else if (bram_we) begin
      wmem[bram_addr] <= bram_din;
      wvld[bram_addr] <= 1'b1;
    end
    bram_dout <= wvld[bram_addr] ? wmem[bram_addr] : init_val(bram_addr);
  end

  // Reference arbiter: first requester at or after ptr, wrapping
  function automatic int predict(input logic [NE-1:0] r, input int ptr);
    for (int k = 0; k < NE; k++) begin
      if (r[(ptr + k) % NE]) return (ptr + k) % NE;
    end
    return -1;
  endfunction

  // Read-return scoreboard
  always @(negedge clk) begin
    if (mon_en && eng_rvalid !== 4'b0000) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected: got rvalid=%b rdata=%h, expected none", eng_rvalid, eng_rdata);
      end else begin
        mon_e = sb_q.pop_front();
        if (eng_rvalid !== mon_e.oh || eng_rdata !== mon_e.data) begin
          errors++;
          $display("FAIL read_return: got rvalid=%b rdata=%h, expected rvalid=%b rdata=%h",
                   eng_rvalid, eng_rdata, mon_e.oh, mon_e.data);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_eng(input int i, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    eng_req[i] = r;
    eng_we[i]  = w;
    eng_addr[i*AW +: AW]  = a;
    eng_wdata[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    eng_req = 4'b1010;
    @(negedge clk);
    checks++;
    if ({rdy, finished_all, done, l_step} !== {3'b000, 32'd0}) begin
      errors++;
      $display("FAIL reset_status: got %b/%0d, expected 000/0", {rdy, finished_all, done}, l_step);
    end
    checks++;
    if ({eng_rvalid, eng_rdata, bram_we} !== {4'b0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got rvalid=%b rdata=%h we=%b, expected 0/0/0", eng_rvalid, eng_rdata, bram_we);
    end
    checks++;
    if (conflict !== 4'b1010) begin
      errors++;
      $display("FAIL idle_conflict: got %b, expected 1010", conflict);
    end
    next_cycle();
    rst = 1'b0;
    eng_req = '0;
    @(negedge clk);
    checks++;
    if ({rdy, conflict} !== 5'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got rdy=%b conflict=%b, expected 0/0000", rdy, conflict);
    end
  endtask

  task automatic test_single_read();
    mon_en = 1'b1;
    next_cycle();
    start = 1'b1;
    @(negedge clk);
    next_cycle();
    start = 1'b0;
    drive_eng(0, 1'b1, 1'b0, 13'd5, 32'd0);
    sb_q.push_back('{oh: 4'b0001, data: 32'hAB});
    @(negedge clk);
    exp_ptr = 1;
    checks++;
    if ({rdy, finished_all, done, l_step} !== {3'b110, 32'd0}) begin
      errors++;
      $display("FAIL start_status: got %b/%0d, expected 110/0", {rdy, finished_all, done}, l_step);
    end
    checks++;
    if ({conflict, bram_addr, bram_we} !== {4'b0000, 13'd5, 1'b0}) begin
      errors++;
      $display("FAIL single_read_port: got conflict=%b addr=%0d we=%b, expected 0000/5/0", conflict, bram_addr, bram_we);
    end
    next_cycle();
    eng_req = '0;
    @(negedge clk);
    checks++;
    if ({rdy, finished_all} !== 2'b10) begin
      errors++;
      $display("FAIL fa_one_cycle: got rdy=%b fa=%b, expected 1/0", rdy, finished_all);
    end
  endtask

  task automatic test_round_robin();
    int g;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      for (int i = 0; i < NE; i++) drive_eng(i, 1'b1, 1'b0, 13'(16 + i), 32'd0);
      g = predict(4'b1111, exp_ptr);
      sb_q.push_back('{oh: 4'(1 << g), data: init_val(13'(16 + g))});
      @(negedge clk);
      checks++;
      if (conflict !== (4'b1111 & ~4'(1 << g)) || bram_addr !== 13'(16 + g) || bram_we !== 1'b0) begin
        errors++;
        $display("FAIL rr_grant c%0d: got conflict=%b addr=%0d, expected grant %0d", c, conflict, bram_addr, g);
      end
      exp_ptr = (g + 1) % NE;
    end
    next_cycle();
    eng_req = '0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int g;
    next_cycle();
    drive_eng(1, 1'b1, 1'b0, 13'd8, 32'd0);
    g = predict(4'b0010, exp_ptr);
    sb_q.push_back('{oh: 4'(1 << g), data: init_val(13'd8)});
    exp_ptr = (g + 1) % NE;
    @(negedge clk);
    next_cycle();
    drive_eng(2, 1'b1, 1'b1, 13'd7, 32'h10);
    g = predict(4'b0110, exp_ptr);
    exp_ptr = (g + 1) % NE;
    @(negedge clk);
    checks++;
    if ({bram_we, bram_addr, bram_din, conflict} !== {1'b1, 13'd7, 32'h10, 4'b0010} || g != 2) begin
      errors++;
      $display("FAIL write_grant: got we=%b addr=%0d din=%h conflict=%b, expected 1/7/10/0010",
               bram_we, bram_addr, bram_din, conflict);
    end
    next_cycle();
    drive_eng(2, 1'b0, 1'b0, 13'd0, 32'd0);
    g = predict(4'b0010, exp_ptr);
    sb_q.push_back('{oh: 4'(1 << g), data: init_val(13'd8)});
    exp_ptr = (g + 1) % NE;
    @(negedge clk);
    checks++;
    if ({bram_we, bram_addr, conflict, eng_rvalid} !== {1'b0, 13'd8, 4'b0000, 4'b0000}) begin
      errors++;
      $display("FAIL read_after_write: got we=%b addr=%0d conflict=%b rvalid=%b, expected 0/8/0000/0000",
               bram_we, bram_addr, conflict, eng_rvalid);
    end
    next_cycle();
    drive_eng(1, 1'b0, 1'b0, 13'd0, 32'd0);
    drive_eng(3, 1'b1, 1'b0, 13'd7, 32'd0);
    g = predict(4'b1000, exp_ptr);
    sb_q.push_back('{oh: 4'(1 << g), data: 32'h10});
    exp_ptr = (g + 1) % NE;
    @(negedge clk);
    next_cycle();
    eng_req = '0;
    @(negedge clk);
    checks++;
    if ({bram_we, bram_addr, conflict} !== {1'b0, 13'd7, 4'b0000}) begin
      errors++;
      $display("FAIL idle_hold_addr: got we=%b addr=%0d conflict=%b, expected 0/7/0000", bram_we, bram_addr, conflict);
    end
  endtask

  task automatic test_steps();
    logic [NE-1:0] pat [6];
    pat = '{4'b0001, 4'b0000, 4'b0100, 4'b0010, 4'b0000, 4'b1000};
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 6; c++) begin
        next_cycle();
        eng_finished = pat[c];
        @(negedge clk);
        checks++;
        if ({rdy, finished_all, done, l_step} !== {3'b100, 32'(s)}) begin
          errors++;
          $display("FAIL step_run s%0d c%0d: got %b/%0d, expected 100/%0d", s, c, {rdy, finished_all, done}, l_step, s);
        end
      end
      next_cycle();
      eng_finished = '0;
      @(negedge clk);
      checks++;
      if ({rdy, finished_all, done, l_step} !== {3'b000, 32'(s + 1)}) begin
        errors++;
        $display("FAIL step_end s%0d: got %b/%0d, expected 000/%0d", s, {rdy, finished_all, done}, l_step, s + 1);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (s < 2 && {rdy, finished_all, done, l_step} !== {3'b110, 32'(s + 1)}) begin
        errors++;
        $display("FAIL step_restart s%0d: got %b/%0d, expected 110/%0d", s, {rdy, finished_all, done}, l_step, s + 1);
      end else if (s == 2 && {rdy, finished_all, done, l_step} !== {3'b001, 32'd3}) begin
        errors++;
        $display("FAIL step_done: got %b/%0d, expected 001/3", {rdy, finished_all, done}, l_step);
      end
    end
  endtask

  task automatic test_finished_mask();
    logic [2:0] exp_f [7];
    logic [DW-1:0] exp_l [7];
    exp_f = '{3'b001, 3'b001, 3'b110, 3'b100, 3'b100, 3'b100, 3'b100};
    exp_l = '{32'd3, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      eng_finished = (c < 3) ? 4'b1111 : 4'b0000;
      start = (c == 1 || c == 5);
      @(negedge clk);
      checks++;
      if ({rdy, finished_all, done, l_step} !== {exp_f[c], exp_l[c]}) begin
        errors++;
        $display("FAIL mask_restart c%0d: got %b/%0d, expected %b/%0d", c, {rdy, finished_all, done}, l_step, exp_f[c], exp_l[c]);
      end
    end
    next_cycle();
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    int g;
    next_cycle();
    eng_finished = 4'b1111;
    @(negedge clk);
    next_cycle();
    eng_finished = '0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    checks++;
    if ({rdy, finished_all, l_step} !== {2'b11, 32'd1}) begin
      errors++;
      $display("FAIL pre_reset_step: got %b/%0d, expected 11/1", {rdy, finished_all}, l_step);
    end
    next_cycle();
    rst = 1'b1;
    drive_eng(0, 1'b1, 1'b1, 13'd9, 32'h77);
    @(negedge clk);
    checks++;
    if ({bram_we, bram_addr, bram_din} !== {1'b1, 13'd9, 32'h77}) begin
      errors++;
      $display("FAIL write_before_rst: got we=%b addr=%0d din=%h, expected 1/9/77", bram_we, bram_addr, bram_din);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({bram_we, rdy, finished_all, done, l_step, conflict, eng_rvalid} !== {4'b0000, 32'd0, 4'b0001, 4'b0000}) begin
      errors++;
      $display("FAIL midrun_reset: got we=%b rdy=%b l_step=%0d conflict=%b rvalid=%b, expected 0/0/0/0001/0000",
               bram_we, rdy, l_step, conflict, eng_rvalid);
    end
    next_cycle();
    rst = 1'b0;
    eng_req = '0;
    eng_we = '0;
    exp_ptr = 0;
    start = 1'b1;
    @(negedge clk);
    next_cycle();
    start = 1'b0;
    for (int i = 0; i < NE; i++) drive_eng(i, 1'b1, 1'b0, 13'(16 + i), 32'd0);
    g = predict(4'b1111, exp_ptr);
    sb_q.push_back('{oh: 4'(1 << g), data: init_val(13'(16 + g))});
    exp_ptr = (g + 1) % NE;
    @(negedge clk);
    checks++;
    if ({rdy, finished_all, conflict, bram_addr} !== {2'b11, 4'b1110, 13'd16}) begin
      errors++;
      $display("FAIL ptr_after_reset: got rdy=%b fa=%b conflict=%b addr=%0d, expected 1/1/1110/16",
               rdy, finished_all, conflict, bram_addr);
    end
    next_cycle();
    rst = 1'b1;
    eng_req = '0;
    drive_eng(1, 1'b1, 1'b0, 13'd20, 32'd0);
    @(negedge clk);
    checks++;
    if ({conflict, bram_addr} !== {4'b0000, 13'd20}) begin
      errors++;
      $display("FAIL read_during_rst: got conflict=%b addr=%0d, expected 0000/20", conflict, bram_addr);
    end
    next_cycle();
    eng_req = '0;
    @(negedge clk);
    checks++;
    if ({eng_rvalid, eng_rdata, rdy} !== {4'b0000, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL rvalid_dropped: got rvalid=%b rdata=%h rdy=%b, expected 0000/0/0", eng_rvalid, eng_rdata, rdy);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    eng_req = '0;
    eng_we = '0;
    eng_addr = '0;
    eng_wdata = '0;
    eng_finished = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_read();
    test_steps();
    test_finished_mask();
    test_reset_midrun();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d outstanding reads, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
